// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode character writer.
// Screen geometry defaults, ASCII control codes and the writer FSM encoding.
package text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Character cell store: one write port, one synchronous read port, no content reset.
// A read of the address being written in the same cycle returns the old byte.
module text_ram #(
    parameter int DEPTH = 2400,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_writer.sv
// Terminal-style text writer: accepts ASCII codes into a cell RAM with cursor control,
// blanks the screen on request/reset, and serves the pixel-driven read path at 1 clk latency.
module text_writer #(
    parameter int COLS   = text_pkg::COLS,
    parameter int ROWS   = text_pkg::ROWS,
    parameter int CHAR_W = text_pkg::CHAR_W,
    parameter int CHAR_H = text_pkg::CHAR_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       clear,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [7:0] ascii_char,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic       busy
);
    import text_pkg::*;

    localparam int          CELLS     = COLS * ROWS;
    localparam int          XSH       = $clog2(CHAR_W);
    localparam int          YSH       = $clog2(CHAR_H);
    localparam logic [11:0] COLS_A    = 12'(COLS);
    localparam logic [11:0] LAST_ADDR = 12'(CELLS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [11:0] X_LIM     = 12'(COLS * CHAR_W);
    localparam logic [11:0] Y_LIM     = 12'(ROWS * CHAR_H);

    state_t      state;
    logic [11:0] clr_addr;
    logic        accept;
    logic        printable;
    logic        newline;
    logic        bs_move;
    logic [6:0]  bs_col;
    logic [4:0]  bs_row;
    logic [4:0]  next_row;
    logic [11:0] cur_addr;
    logic [11:0] bs_addr;
    logic        we;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    logic [11:0] cell_x;
    logic [11:0] cell_y;
    logic [11:0] raddr;
    logic [7:0]  rdata;
    logic        oob;
    logic        oob_q;

    assign char_ready = (state == IDLE) && !clear;
    assign busy       = (state == CLEAR);
    assign accept     = char_valid && char_ready;
    assign printable  = is_printable(char_data);
    assign newline    = (char_data == LF) || (char_data == CR);
    assign next_row   = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
    assign cur_addr   = 12'(cursor_row) * COLS_A + 12'(cursor_col);
    assign bs_addr    = 12'(bs_row) * COLS_A + 12'(bs_col);

    // Backspace target: step left, or up to the end of the previous row; stuck at (0,0).
    always_comb begin
        bs_move = 1'b0;
        bs_col  = cursor_col;
        bs_row  = cursor_row;
        if (cursor_col != 7'd0) begin
            bs_move = 1'b1;
            bs_col  = cursor_col - 7'd1;
        end else if (cursor_row != 5'd0) begin
            bs_move = 1'b1;
            bs_col  = LAST_COL;
            bs_row  = cursor_row - 5'd1;
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdata = SPACE;
        if (state == CLEAR) begin
            we = 1'b1;
        end else if (accept) begin
            if (printable) begin
                we    = 1'b1;
                waddr = cur_addr;
                wdata = char_data;
            end else if ((char_data == BS) && bs_move) begin
                we    = 1'b1;
                waddr = bs_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clr_addr   <= 12'd0;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        clr_addr   <= 12'd0;
                        cursor_col <= 7'd0;
                        cursor_row <= 5'd0;
                        state      <= IDLE;
                    end else begin
                        clr_addr <= clr_addr + 12'd1;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        clr_addr <= 12'd0;
                        state    <= CLEAR;
                    end else if (accept) begin
                        if (printable) begin
                            if (cursor_col == LAST_COL) begin
                                cursor_col <= 7'd0;
                                cursor_row <= next_row;
                            end else begin
                                cursor_col <= cursor_col + 7'd1;
                            end
                        end else if (newline) begin
                            cursor_col <= 7'd0;
                            cursor_row <= next_row;
                        end else if ((char_data == BS) && bs_move) begin
                            cursor_col <= bs_col;
                            cursor_row <= bs_row;
                        end
                    end
                end
            endcase
        end
    end

    // Off-screen pixels read a harmless address; the registered flag substitutes a space.
    assign cell_x = 12'(x[9:XSH]);
    assign cell_y = 12'(y[9:YSH]);
    assign oob    = ({2'b00, x} >= X_LIM) || ({2'b00, y} >= Y_LIM);
    assign raddr  = oob ? 12'd0 : cell_y * COLS_A + cell_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob_q <= 1'b1;
        end else begin
            oob_q <= oob;
        end
    end

    assign ascii_char = oob_q ? SPACE : rdata;

    text_ram #(
        .DEPTH (CELLS),
        .AW    (12)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: table-driven cursor/read vectors plus clear/reset sequences.
module tb_text_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready;
    logic       clear = 1'b0;
    logic [9:0] px = 10'd0;
    logic [9:0] py = 10'd0;
    logic [7:0] ascii_char;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    text_writer dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear      (clear),
        .x          (px),
        .y          (py),
        .ascii_char (ascii_char),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        int         ecol;
        int         erow;
    } cvec_t;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] exp;
    } rvec_t;

    cvec_t cvecs[13];
    rvec_t rvecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        char_valid = 1'b1;
        char_data  = c;
        step();
        char_valid = 1'b0;
    endtask

    task automatic read_cell(input int cx, input int cy, input logic [7:0] exp, input string name);
        px = 10'(cx);
        py = 10'(cy);
        step();
        check(name, {24'd0, ascii_char}, {24'd0, exp});
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check({name, "_col"}, {25'd0, cursor_col}, col);
        check({name, "_row"}, {27'd0, cursor_row}, row);
    endtask

    // Counts edges until busy drops; optionally pulses clear mid-way (should be ignored).
    task automatic wait_idle(input int pulse_at, output int n);
        n = -1;
        for (int i = 1; i <= 3000; i++) begin
            clear = (i == pulse_at);
            step();
            if (!busy) begin
                n = i;
                break;
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        int n;
        int bad;

        cvecs[0]  = '{8'h41, 1, 0};
        cvecs[1]  = '{8'h42, 2, 0};
        cvecs[2]  = '{8'h01, 2, 0};
        cvecs[3]  = '{8'h0D, 0, 1};
        cvecs[4]  = '{8'h08, 79, 0};
        cvecs[5]  = '{8'h71, 0, 1};
        cvecs[6]  = '{8'h43, 1, 1};
        cvecs[7]  = '{8'h08, 0, 1};
        cvecs[8]  = '{8'h08, 79, 0};
        cvecs[9]  = '{8'h7F, 79, 0};
        cvecs[10] = '{8'h0A, 0, 1};
        cvecs[11] = '{8'h7E, 1, 1};
        cvecs[12] = '{8'h9B, 1, 1};

        rvecs[0] = '{0, 0, 8'h41};
        rvecs[1] = '{8, 15, 8'h42};
        rvecs[2] = '{16, 0, 8'h20};
        rvecs[3] = '{632, 0, 8'h20};
        rvecs[4] = '{0, 16, 8'h7E};
        rvecs[5] = '{15, 31, 8'h20};

        // Reset state
        #3 reset = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_ready", {31'd0, char_ready}, 0);
        check("rst_ascii", {24'd0, ascii_char}, 32'h20);
        check_cursor("rst", 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        wait_idle(0, n);
        check("init_clear_cycles", n, 2400);
        check("init_ready", {31'd0, char_ready}, 1);

        bad = 0;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 80; c++) begin
                px = 10'(c * 8 + (c % 8));
                py = 10'(r * 16 + (r % 16));
                step();
                if (ascii_char !== 8'h20) bad++;
            end
        end
        check("init_all_cells_blank_bad", bad, 0);

        for (int i = 0; i < 13; i++) begin
            send(cvecs[i].data);
            check_cursor($sformatf("vec%0d", i), cvecs[i].ecol, cvecs[i].erow);
        end
        for (int i = 0; i < 6; i++) begin
            read_cell(rvecs[i].x, rvecs[i].y, rvecs[i].exp, $sformatf("rd%0d", i));
        end

        // Exactly one cycle of read latency
        read_cell(0, 0, 8'h41, "lat_pre");
        px = 10'd8;
        #1;
        check("lat_hold", {24'd0, ascii_char}, 32'h41);
        step();
        check("lat_new", {24'd0, ascii_char}, 32'h42);

        // Walk to the last row and fill it, wrapping to (0,0)
        send(8'h0D);
        for (int i = 0; i < 28; i++) send(8'h0A);
        check_cursor("lf_wrap", 0, 0);
        for (int i = 0; i < 29; i++) send(8'h0A);
        check_cursor("last_row", 0, 29);
        for (int i = 0; i < 80; i++) send(8'h5A);
        check_cursor("z_wrap", 0, 0);
        read_cell(632, 464, 8'h5A, "cell2399");
        read_cell(0, 464, 8'h5A, "cell2320");
        read_cell(632, 448, 8'h20, "cell2319");

        send(8'h08);
        check_cursor("bs_origin", 0, 0);
        read_cell(0, 0, 8'h41, "bs_origin_nowrite");

        read_cell(640, 448, 8'h20, "oob_x_alias");
        read_cell(640, 100, 8'h20, "oob_x");
        read_cell(0, 480, 8'h20, "oob_y");
        read_cell(639, 479, 8'h5A, "edge_in");

        // Clear wins over a simultaneous character
        send(8'h0D);
        clear      = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h41;
        #1;
        check("clr_ready", {31'd0, char_ready}, 0);
        step();
        clear      = 1'b0;
        char_valid = 1'b0;
        check("clr_busy", {31'd0, busy}, 1);
        check_cursor("clr_no_accept", 0, 1);
        wait_idle(500, n);
        check("clr_cycles", n, 2400);
        check_cursor("clr_done", 0, 0);
        read_cell(0, 0, 8'h20, "clr_cell0");
        read_cell(632, 464, 8'h20, "clr_cell2399");

        // Reset mid-clear restarts from address 0
        send(8'h0D);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (1000) step();
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 1);
        check("midrst_ready", {31'd0, char_ready}, 0);
        check("midrst_ascii", {24'd0, ascii_char}, 32'h20);
        check_cursor("midrst", 0, 0);
        step();
        reset = 1'b0;
        wait_idle(0, n);
        check("midrst_cycles", n, 2400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
